// File: rtl/keypad_answer_capture_pkg.sv
// Shared key codes, entry FSM states and the row-drive reset pattern for keypad_answer_capture.
package keypad_answer_capture_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;
    localparam logic [3:0] ROW_RST  = 4'b1110;

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_e;

    // Rows 0..2 hold 1-9, row 3 holds '*', '0' and '#'.
    function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            unique case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_answer_capture_if.sv
// Answer channel between the keypad capture block (master) and the game controller (slave).
interface keypad_answer_capture_if #(
    parameter int unsigned RESP_W = 4
);
    logic              arm;
    logic [RESP_W-1:0] response;
    logic              input_done;
    logic              overflow;
    logic              key_valid;
    logic [3:0]        key_code;

    modport master (
        input  arm,
        output response, input_done, overflow, key_valid, key_code
    );

    modport slave (
        output arm,
        input  response, input_done, overflow, key_valid, key_code
    );
endinterface

// File: rtl/keypad_answer_capture_keypad_scan.sv
// Row scanner, column synchroniser, per-scan key resolution and press/release debouncer.
module keypad_scan
    import keypad_answer_capture_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n_i,
    output logic [3:0] row_n_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       scan_tick_o
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEB_SCANS + 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [3:0]    row_q, row_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [2:0]    col_s1_q, col_s2_q;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    hit_code_q, hit_code_d;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          kv_q, kv_d;
    logic [3:0]    kc_q, kc_d;

    logic          slot_end;
    logic [2:0]    col_act;
    logic [1:0]    row_keys;
    logic [2:0]    hit_sum;
    logic [1:0]    new_hits;
    logic [3:0]    new_code;
    logic [3:0]    scan_code;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            row_q      <= ROW_RST;
            ridx_q     <= '0;
            col_s1_q   <= '1;
            col_s2_q   <= '1;
            hits_q     <= '0;
            hit_code_q <= KEY_NONE;
            pressed_q  <= 1'b0;
            cnt_q      <= '0;
            cand_q     <= KEY_NONE;
            kv_q       <= 1'b0;
            kc_q       <= '0;
        end else begin
            slot_q     <= slot_d;
            row_q      <= row_d;
            ridx_q     <= ridx_d;
            col_s1_q   <= col_n_i;
            col_s2_q   <= col_s1_q;
            hits_q     <= hits_d;
            hit_code_q <= hit_code_d;
            pressed_q  <= pressed_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            kv_q       <= kv_d;
            kc_q       <= kc_d;
        end
    end

    always_comb begin
        slot_d     = slot_q;
        row_d      = row_q;
        ridx_d     = ridx_q;
        hits_d     = hits_q;
        hit_code_d = hit_code_q;
        pressed_d  = pressed_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        kv_d       = 1'b0;
        kc_d       = kc_q;
        cnt_nx     = '0;
        scan_code  = KEY_NONE;

        slot_end = (slot_q == SW'(SCAN_DIV - 1));
        col_act  = ~col_s2_q;
        row_keys = {1'b0, col_act[0]} + {1'b0, col_act[1]} + {1'b0, col_act[2]};
        col_idx  = col_act[0] ? 2'd0 : (col_act[1] ? 2'd1 : 2'd2);
        hit_sum  = {1'b0, hits_q} + {1'b0, row_keys};
        new_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        new_code = (row_keys == 2'd1) ? key_at(ridx_q, col_idx) : hit_code_q;

        if (!slot_end) begin
            slot_d = slot_q + SW'(1);
        end else begin
            slot_d = '0;
            row_d  = {row_q[2:0], row_q[3]};
            ridx_d = ridx_q + 2'd1;
            if (ridx_q != 2'd3) begin
                hits_d     = new_hits;
                hit_code_d = new_code;
            end else begin
                // Last row just sampled: resolve this scan and feed it to the debouncer.
                hits_d     = '0;
                hit_code_d = KEY_NONE;
                scan_code  = (new_hits == 2'd1) ? new_code : KEY_NONE;
                if (!pressed_q) begin
                    if (scan_code == KEY_NONE) begin
                        cnt_d  = '0;
                        cand_d = KEY_NONE;
                    end else begin
                        cnt_nx = (scan_code == cand_q) ? cnt_q + CW'(1) : CW'(1);
                        cand_d = scan_code;
                        if (cnt_nx >= CW'(DEB_SCANS)) begin
                            kv_d      = 1'b1;
                            kc_d      = scan_code;
                            pressed_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end
                end else begin
                    if (scan_code == KEY_NONE) begin
                        cnt_nx = cnt_q + CW'(1);
                        if (cnt_nx >= CW'(DEB_SCANS)) begin
                            pressed_d = 1'b0;
                            cnt_d     = '0;
                            cand_d    = KEY_NONE;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
        end
    end

    assign row_n_o     = row_q;
    assign key_valid_o = kv_q;
    assign key_code_o  = kc_q;
    assign scan_tick_o = slot_end && (ridx_q == 2'd3);

endmodule

// File: rtl/keypad_answer_capture.sv
// Keypad answer capture: digit accumulation and commit on '#'.
// Optional DIRECT_BTN_EN adds discrete active-low digit buttons btn_n[9:0].
module keypad_answer_capture
    import keypad_answer_capture_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_SCANS  = 4,
    parameter int unsigned RESP_W     = 4,
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
`ifdef DIRECT_BTN_EN
    input  logic [9:0] btn_n,
`endif
    keypad_answer_capture_if.master ans
);

    localparam int unsigned DW       = $clog2(MAX_DIGITS + 1);
    localparam int unsigned CW       = $clog2(DEB_SCANS + 1);
    localparam int unsigned RESP_MAX = (1 << RESP_W) - 1;

    logic       scan_kv;
    logic [3:0] scan_code;
    logic       scan_tick;
    logic       evt_kv;
    logic [3:0] evt_code;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_SCANS(DEB_SCANS)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .col_n_i    (col_n),
        .row_n_o    (row_n),
        .key_valid_o(scan_kv),
        .key_code_o (scan_code),
        .scan_tick_o(scan_tick)
    );

`ifdef DIRECT_BTN_EN
    logic [9:0]    btn_s1_q, btn_s2_q;
    logic [9:0]    btn_fired_q;
    logic [CW-1:0] btn_cnt_q [10];
    logic [9:0]    btn_ready;
    logic          btn_any;
    logic [3:0]    btn_sel;
    logic          btn_kv_q;
    logic [3:0]    btn_code_q;
    logic [3:0]    last_code_q;

    always_comb begin
        btn_any = 1'b0;
        btn_sel = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            btn_ready[i] = scan_tick && !btn_s2_q[i] && !btn_fired_q[i]
                           && (btn_cnt_q[i] + CW'(1) >= CW'(DEB_SCANS));
        end
        for (int unsigned i = 10; i > 0; i--) begin
            if (btn_ready[i-1]) begin
                btn_any = 1'b1;
                btn_sel = 4'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q    <= '1;
            btn_s2_q    <= '1;
            btn_fired_q <= '0;
            for (int unsigned i = 0; i < 10; i++) btn_cnt_q[i] <= '0;
            btn_kv_q    <= 1'b0;
            btn_code_q  <= '0;
            last_code_q <= '0;
        end else begin
            btn_s1_q   <= btn_n;
            btn_s2_q   <= btn_s1_q;
            btn_kv_q   <= btn_any;
            btn_code_q <= btn_sel;
            if (evt_kv) last_code_q <= evt_code;
            if (scan_tick) begin
                for (int unsigned i = 0; i < 10; i++) begin
                    if (btn_s2_q[i]) begin
                        btn_cnt_q[i]   <= '0;
                        btn_fired_q[i] <= 1'b0;
                    end else begin
                        if (btn_cnt_q[i] < CW'(DEB_SCANS)) btn_cnt_q[i] <= btn_cnt_q[i] + CW'(1);
                        if (btn_ready[i]) btn_fired_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Keypad and button events land on the same cycle after a scan; the keypad takes it.
    assign evt_kv       = scan_kv | btn_kv_q;
    assign evt_code     = scan_kv ? scan_code : btn_code_q;
    assign ans.key_code = evt_kv ? evt_code : last_code_q;
`else
    logic unused_scan_tick;
    assign unused_scan_tick = scan_tick;
    assign evt_kv       = scan_kv;
    assign evt_code     = scan_code;
    assign ans.key_code = scan_code;
`endif

    assign ans.key_valid = evt_kv;

    state_e            state_q, state_d;
    logic              arm_q;
    logic [6:0]        acc_q, acc_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= ans.arm;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        ovf_d   = ovf_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (ans.arm && !arm_q) begin
                    resp_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (evt_kv) begin
                    if (evt_code < 4'd10) begin
                        if (cnt_q < DW'(MAX_DIGITS)) begin
                            acc_d = acc_q * 7'd10 + {3'b000, evt_code};
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else if (evt_code == KEY_STAR) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (evt_code == KEY_HASH && cnt_q != '0) begin
                        if (32'(acc_q) > RESP_MAX) begin
                            resp_d = '1;
                            ovf_d  = 1'b1;
                        end else begin
                            resp_d = RESP_W'(acc_q);
                            ovf_d  = 1'b0;
                        end
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // Closing the window overrides any same-cycle commit; response keeps its old value.
        if (!ans.arm) begin
            state_d = IDLE;
            done_d  = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            resp_d  = resp_q;
            ovf_d   = ovf_q;
        end
    end

    assign ans.response   = resp_q;
    assign ans.overflow   = ovf_q;
    assign ans.input_done = done_q;

endmodule
